// File: rtl/sb_pkg.sv
// sb_pkg -- shared constants for the switch box: side indices, select
// encodings, config word field offsets and widths.
// Build option: SWITCH_BOX_PIPE_REG_EN enables the per-side output registers
// (config bits [11:8] become writable register enables).
package sb_pkg;

    localparam int NUM_SIDES = 4;
    localparam int SIDE_0    = 0;
    localparam int SIDE_1    = 1;
    localparam int SIDE_2    = 2;
    localparam int SIDE_3    = 3;

    // Select codes 0..2 pick among the other three sides, 3 picks the PE.
    typedef enum logic [1:0] {
        SEL_0  = 2'd0,
        SEL_1  = 2'd1,
        SEL_2  = 2'd2,
        SEL_PE = 2'd3
    } sel_e;

    localparam int SEL_W       = 2;
    localparam int CFG_SEL_OFS = 0;   // [2s+1:2s] select for side s
    localparam int CFG_REN_OFS = 8;   // [8+s] register enable for side s
    localparam int CFG_USED_W  = 12;  // bits actually stored per track
    localparam int CFG_WORD_W  = 32;  // bus width of a config word

`ifdef SWITCH_BOX_PIPE_REG_EN
    localparam logic [CFG_USED_W-1:0] CFG_WR_MASK = 12'hFFF;
`else
    localparam logic [CFG_USED_W-1:0] CFG_WR_MASK = 12'h0FF;
`endif

    // Map a 0..2 select on output side out_side to the source side index:
    // the remaining sides in ascending order, skipping out_side itself.
    function automatic logic [1:0] src_side(input logic [1:0] out_side,
                                            input logic [1:0] sel);
        return (sel < out_side) ? sel : sel + 2'd1;
    endfunction

endpackage

// File: rtl/sb_track_mux.sv
// sb_track_mux -- one track of the switch box: four 4:1 muxes, one per
// output side, plus optional per-side output registers.
// Build option: SWITCH_BOX_PIPE_REG_EN adds the output registers.
module sb_track_mux
    import sb_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                                 clk_i,
    input  logic                                 rst_n_i,
    input  logic                                 stall_i,
    input  logic [NUM_SIDES-1:0][WIDTH-1:0]      in_i,
    input  logic [WIDTH-1:0]                     pe_i,
    input  logic [CFG_USED_W-1:0]                cfg_i,
    output logic [NUM_SIDES-1:0][WIDTH-1:0]      out_o
);

    logic [NUM_SIDES-1:0][WIDTH-1:0] mux_d;

    // Per-side source selection from the current track inputs or the PE.
    always_comb begin
        mux_d = '0;
        for (int s = 0; s < NUM_SIDES; s++) begin
            if (cfg_i[CFG_SEL_OFS+SEL_W*s +: SEL_W] == SEL_PE)
                mux_d[s] = pe_i;
            else
                mux_d[s] = in_i[src_side(2'(s), cfg_i[CFG_SEL_OFS+SEL_W*s +: SEL_W])];
        end
    end

`ifdef SWITCH_BOX_PIPE_REG_EN
    logic [NUM_SIDES-1:0][WIDTH-1:0] out_q;

    // Output registers load every unstalled cycle, whether or not selected,
    // so the mux result always goes through the old config at a config edge.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            out_q <= '0;
        else if (!stall_i)
            out_q <= mux_d;
    end

    // Per-side choice between the registered and the combinational path.
    always_comb begin
        out_o = mux_d;
        for (int s = 0; s < NUM_SIDES; s++)
            if (cfg_i[CFG_REN_OFS+s])
                out_o[s] = out_q[s];
    end
`else
    // Purely combinational build: clock, reset, stall and enables are idle.
    logic unused_ok;
    assign unused_ok = ^{clk_i, rst_n_i, stall_i, cfg_i[CFG_USED_W-1:CFG_REN_OFS]};
    assign out_o     = mux_d;
`endif

endmodule

// File: rtl/switch_box_cfg.sv
// switch_box_cfg -- configurable 4-sided switch box with per-track config
// words, registered config readback and optional output pipeline registers.
// Build option: SWITCH_BOX_PIPE_REG_EN enables output registers and stall.
module switch_box_cfg
    import sb_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int NUM_TRACKS = 4,
    parameter int CFG_ADDR_W = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [4*NUM_TRACKS*WIDTH-1:0]     in_bus,
    input  logic [WIDTH-1:0]                  pe_output,
    output logic [4*NUM_TRACKS*WIDTH-1:0]     out_bus,
    input  logic                              stall,
    input  logic                              config_en,
    input  logic                              config_we,
    input  logic [CFG_ADDR_W-1:0]             config_addr,
    input  logic [CFG_WORD_W-1:0]             config_data,
    output logic [CFG_WORD_W-1:0]             config_rd_data
);

    localparam int IDX_W = (NUM_TRACKS > 1) ? $clog2(NUM_TRACKS) : 1;

    logic [NUM_TRACKS-1:0][CFG_USED_W-1:0] cfg_q, cfg_d;
    logic [CFG_WORD_W-1:0]                 rd_q, rd_d;
    logic                                  addr_ok;
    logic [IDX_W-1:0]                      idx;

    assign addr_ok = ({1'b0, config_addr} < (CFG_ADDR_W+1)'(NUM_TRACKS));
    assign idx     = config_addr[IDX_W-1:0];

    // Upper write-data bits carry no state.
    logic unused_data;
    assign unused_data = ^config_data[CFG_WORD_W-1:CFG_USED_W];

    // Config write/read decode; out-of-range writes drop, reads return 0.
    always_comb begin
        cfg_d = cfg_q;
        rd_d  = rd_q;
        if (config_en && config_we && addr_ok)
            cfg_d[idx] = config_data[CFG_USED_W-1:0] & CFG_WR_MASK;
        if (config_en && !config_we)
            rd_d = addr_ok ? CFG_WORD_W'(cfg_q[idx]) : '0;
    end

    // Config store and readback register; reset discards any in-flight write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_q <= '0;
            rd_q  <= '0;
        end else begin
            cfg_q <= cfg_d;
            rd_q  <= rd_d;
        end
    end

    assign config_rd_data = rd_q;

    for (genvar t = 0; t < NUM_TRACKS; t++) begin : g_trk
        logic [NUM_SIDES-1:0][WIDTH-1:0] trk_in, trk_out;

        for (genvar s = 0; s < NUM_SIDES; s++) begin : g_side
            assign trk_in[s] = in_bus[((s*NUM_TRACKS+t)*WIDTH) +: WIDTH];
            assign out_bus[((s*NUM_TRACKS+t)*WIDTH) +: WIDTH] = trk_out[s];
        end

        sb_track_mux #(.WIDTH(WIDTH)) u_trk (
            .clk_i   (clk),
            .rst_n_i (rst_n),
            .stall_i (stall),
            .in_i    (trk_in),
            .pe_i    (pe_output),
            .cfg_i   (cfg_q[t]),
            .out_o   (trk_out)
        );
    end

endmodule
